// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: DEPTH stages of {valid, ctrl, data, rd_addr} with stall hold and flush bubbles.
// Define PIPE_STAGE_PERF_EN to build saturating stall/bubble counters; otherwise both counter outputs read zero.
module pipe_stage_reg #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 32,
  parameter int NDATA  = 2,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    valid_i,
  input  logic                    stall_i,
  input  logic                    flush_i,
  input  logic [CTRL_W-1:0]       ctrl_i,
  input  logic [NDATA*DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0]       rd_addr_i,
  output logic                    valid_o,
  output logic [CTRL_W-1:0]       ctrl_o,
  output logic [NDATA*DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0]       rd_addr_o,
  output logic [15:0]             stall_cnt_o,
  output logic [15:0]             bubble_cnt_o
);

  localparam int DW = NDATA * DATA_W;

  logic [DEPTH-1:0] valid_q;
  logic [CTRL_W-1:0] ctrl_q [DEPTH];
  logic [DW-1:0]     data_q [DEPTH];
  logic [ADDR_W-1:0] rd_q   [DEPTH];

  // A flush always wins over a stall for stage 0, so a held instruction there is killed.
  logic load_bubble;
  logic load_input;
  assign load_bubble = flush_i | (~stall_i & ~valid_i);
  assign load_input  = ~flush_i & ~stall_i & valid_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || load_bubble) begin
      valid_q[0] <= 1'b0;
      ctrl_q[0]  <= '0;
      data_q[0]  <= '0;
      rd_q[0]    <= '0;
    end else if (load_input) begin
      valid_q[0] <= 1'b1;
      ctrl_q[0]  <= ctrl_i;
      data_q[0]  <= data_i;
      rd_q[0]    <= rd_addr_i;
    end
  end

  // Later stages only ever copy their predecessor, so bubbles stay all-zero down the chain.
  for (genvar s = 1; s < DEPTH; s++) begin : g_stage
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        valid_q[s] <= 1'b0;
        ctrl_q[s]  <= '0;
        data_q[s]  <= '0;
        rd_q[s]    <= '0;
      end else if (!stall_i) begin
        valid_q[s] <= valid_q[s-1];
        ctrl_q[s]  <= ctrl_q[s-1];
        data_q[s]  <= data_q[s-1];
        rd_q[s]    <= rd_q[s-1];
      end
    end
  end

  assign valid_o   = valid_q[DEPTH-1];
  assign ctrl_o    = ctrl_q[DEPTH-1];
  assign data_o    = data_q[DEPTH-1];
  assign rd_addr_o = rd_q[DEPTH-1];

`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] bubble_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (stall_i && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (load_bubble && bubble_cnt_q != 16'hFFFF)
        bubble_cnt_q <= bubble_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`else
  assign stall_cnt_o  = 16'h0000;
  assign bubble_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: DEPTH 1/2/3 instances share one stimulus stream and are compared to a slot-array model.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic        v;
    logic [3:0]  c;
    logic [63:0] d;
    logic [4:0]  r;
  } slot_t;

  logic        clk = 1'b0;
  logic        rst, valid_in, stall, flush;
  logic [3:0]  ctrl_in;
  logic [63:0] data_in;
  logic [4:0]  rd_in;

  logic        valid_w  [3];
  logic [3:0]  ctrl_w   [3];
  logic [63:0] data_w   [3];
  logic [4:0]  rd_w     [3];
  logic [15:0] scnt_w   [3];
  logic [15:0] bcnt_w   [3];

  slot_t       mdl [3][3];
  int unsigned m_stall, m_bubble;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pipe_stage_reg #(.CTRL_W(4), .DATA_W(32), .NDATA(2), .ADDR_W(5), .DEPTH(g + 1)) dut (
      .clk_i(clk), .rst_i(rst), .valid_i(valid_in), .stall_i(stall), .flush_i(flush),
      .ctrl_i(ctrl_in), .data_i(data_in), .rd_addr_i(rd_in),
      .valid_o(valid_w[g]), .ctrl_o(ctrl_w[g]), .data_o(data_w[g]), .rd_addr_o(rd_w[g]),
      .stall_cnt_o(scnt_w[g]), .bubble_cnt_o(bcnt_w[g])
    );
  end

  function automatic logic [15:0] exp_cnt(int unsigned v);
`ifdef PIPE_STAGE_PERF_EN
    return (v > 65535) ? 16'hFFFF : v[15:0];
`else
    return 16'h0000;
`endif
  endfunction

  // Advance one rising edge, apply the pipeline rules to the model, then wait for the sampling edge.
  task automatic tick();
    slot_t in_slot;
    @(posedge clk);
    in_slot = valid_in ? slot_t'{1'b1, ctrl_in, data_in, rd_in} : slot_t'(0);
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        for (int s = 0; s < 3; s++) mdl[i][s] = '0;
      end else begin
        if (!stall)
          for (int s = i; s > 0; s--) mdl[i][s] = mdl[i][s-1];
        if (flush) mdl[i][0] = '0;
        else if (!stall) mdl[i][0] = in_slot;
      end
    end
    if (rst) begin
      m_stall = 0;
      m_bubble = 0;
    end else begin
      if (stall) m_stall++;
      if (flush || (!stall && !valid_in)) m_bubble++;
    end
    @(negedge clk);
  endtask

  task automatic randomize_inputs();
    valid_in = 1'($urandom);
    ctrl_in  = 4'($urandom);
    data_in  = {$urandom, $urandom};
    rd_in    = 5'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      randomize_inputs();
      stall = 1'($urandom);
      flush = 1'($urandom);
      tick();
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if ({valid_w[i], ctrl_w[i], data_w[i], rd_w[i], scnt_w[i], bcnt_w[i]} !== '0) begin
          n_errors++;
          $display("[TB] FAIL reset depth%0d cyc%0d: got v=%b c=%h d=%h r=%h sc=%h bc=%h, need all zero",
                   i + 1, k, valid_w[i], ctrl_w[i], data_w[i], rd_w[i], scnt_w[i], bcnt_w[i]);
        end
      end
    end
  endtask

  task automatic test_advance();
    slot_t want;
    want = '{1'b1, 4'b1010, {32'h1234_5678, 32'hDEAD_BEEF}, 5'd7};
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    valid_in = 1'b1; ctrl_in = 4'b1010; data_in = {32'h1234_5678, 32'hDEAD_BEEF}; rd_in = 5'd7;
    tick();
    n_checks++;
    if ({valid_w[0], ctrl_w[0], data_w[0], rd_w[0]} !== want) begin
      n_errors++;
      $display("[TB] FAIL advance_depth1: got %h, need %h", {valid_w[0], ctrl_w[0], data_w[0], rd_w[0]}, want);
    end
    for (int k = 1; k <= 3; k++) begin
      valid_in = 1'b0; ctrl_in = 4'($urandom); data_in = {$urandom, $urandom};
      if (k == 3) begin
        n_checks++;
        if (valid_w[2] !== 1'b1 || ctrl_w[2] !== 4'b1010) begin
          n_errors++;
          $display("[TB] FAIL advance_depth3_pre: got v=%b c=%h, need v=1 c=a", valid_w[2], ctrl_w[2]);
        end
      end
      tick();
      if (k == 1) begin
        n_checks++;
        if (valid_w[2] !== 1'b0) begin
          n_errors++;
          $display("[TB] FAIL advance_depth3_early: got v=%b, need 0", valid_w[2]);
        end
      end
      if (k == 2) begin
        n_checks++;
        if ({valid_w[2], ctrl_w[2], data_w[2], rd_w[2]} !== want) begin
          n_errors++;
          $display("[TB] FAIL advance_depth3: got %h, need %h", {valid_w[2], ctrl_w[2], data_w[2], rd_w[2]}, want);
        end
      end
      if (k == 3) begin
        n_checks++;
        if (valid_w[2] !== 1'b0 || ctrl_w[2] !== 4'd0) begin
          n_errors++;
          $display("[TB] FAIL advance_depth3_after: got v=%b c=%h, need v=0 c=0", valid_w[2], ctrl_w[2]);
        end
      end
    end
  endtask

  task automatic test_stall_hold();
    logic [63:0] held_data;
    rst = 1'b1; tick();
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    valid_in = 1'b1; ctrl_in = 4'b1111; rd_in = 5'd3; data_in = {$urandom, $urandom};
    held_data = data_in;
    tick();
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      randomize_inputs();
      tick();
      n_checks++;
      if (valid_w[0] !== 1'b1 || ctrl_w[0] !== 4'b1111 || rd_w[0] !== 5'd3 || data_w[0] !== held_data) begin
        n_errors++;
        $display("[TB] FAIL stall_hold cyc%0d: got v=%b c=%h r=%0d d=%h, need v=1 c=f r=3 d=%h",
                 k, valid_w[0], ctrl_w[0], rd_w[0], data_w[0], held_data);
      end
    end
    n_checks++;
    if (scnt_w[0] !== exp_cnt(4) || bcnt_w[0] !== exp_cnt(0)) begin
      n_errors++;
      $display("[TB] FAIL stall_count: got sc=%0d bc=%0d, need sc=%0d bc=%0d", scnt_w[0], bcnt_w[0], exp_cnt(4), exp_cnt(0));
    end
    stall = 1'b0;
  endtask

  task automatic test_flush_stall();
    logic [63:0] a_data;
    rst = 1'b1; tick();
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    valid_in = 1'b1; ctrl_in = 4'b0110; rd_in = 5'd9; data_in = {$urandom, $urandom};
    a_data = data_in;
    tick();
    ctrl_in = 4'b1001; rd_in = 5'd17; data_in = ~a_data;
    tick();
    n_checks++;
    if (valid_w[1] !== 1'b1 || data_w[1] !== a_data) begin
      n_errors++;
      $display("[TB] FAIL flush_stall_setup: got v=%b d=%h, need v=1 d=%h", valid_w[1], data_w[1], a_data);
    end
    flush = 1'b1; stall = 1'b1; randomize_inputs();
    tick();
    n_checks++;
    if (valid_w[1] !== 1'b1 || ctrl_w[1] !== 4'b0110 || rd_w[1] !== 5'd9 || data_w[1] !== a_data) begin
      n_errors++;
      $display("[TB] FAIL flush_stall_held: got v=%b c=%h r=%0d d=%h, need v=1 c=6 r=9 d=%h",
               valid_w[1], ctrl_w[1], rd_w[1], data_w[1], a_data);
    end
    n_checks++;
    if (valid_w[0] !== 1'b0 || ctrl_w[0] !== 4'd0) begin
      n_errors++;
      $display("[TB] FAIL flush_stall_depth1: got v=%b c=%h, need v=0 c=0", valid_w[0], ctrl_w[0]);
    end
    flush = 1'b0; stall = 1'b0; valid_in = 1'b0;
    tick();
    n_checks++;
    if (valid_w[1] !== 1'b0 || ctrl_w[1] !== 4'd0 || data_w[1] !== 64'd0 || rd_w[1] !== 5'd0) begin
      n_errors++;
      $display("[TB] FAIL flush_stall_killed: got v=%b c=%h r=%0d d=%h, need all zero",
               valid_w[1], ctrl_w[1], rd_w[1], data_w[1]);
    end
  endtask

  task automatic test_invalid_ctrl();
    rst = 1'b1; tick();
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      valid_in = 1'b0; ctrl_in = 4'b1111; data_in = {$urandom, $urandom}; rd_in = 5'($urandom);
      tick();
      n_checks++;
      if (bcnt_w[2] !== exp_cnt(k)) begin
        n_errors++;
        $display("[TB] FAIL bubble_count edge%0d: got %0d, need %0d", k, bcnt_w[2], exp_cnt(k));
      end
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (valid_w[i] !== 1'b0 || ctrl_w[i] !== 4'd0) begin
          n_errors++;
          $display("[TB] FAIL invalid_ctrl depth%0d edge%0d: got v=%b c=%h, need v=0 c=0", i + 1, k, valid_w[i], ctrl_w[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 2000; k++) begin
      randomize_inputs();
      valid_in = ($urandom_range(0, 9) < 7);
      rst   = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 4) == 0);
      tick();
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if ({valid_w[i], ctrl_w[i], data_w[i], rd_w[i]} !== mdl[i][i]) begin
          n_errors++;
          $display("[TB] FAIL random depth%0d cyc%0d: got %h, need %h", i + 1, k,
                   {valid_w[i], ctrl_w[i], data_w[i], rd_w[i]}, mdl[i][i]);
        end
        n_checks++;
        if (scnt_w[i] !== exp_cnt(m_stall) || bcnt_w[i] !== exp_cnt(m_bubble)) begin
          n_errors++;
          $display("[TB] FAIL random_counters depth%0d cyc%0d: got sc=%0d bc=%0d, need sc=%0d bc=%0d",
                   i + 1, k, scnt_w[i], bcnt_w[i], exp_cnt(m_stall), exp_cnt(m_bubble));
        end
      end
    end
    rst = 1'b0; flush = 1'b0; stall = 1'b0;
  endtask

  task automatic test_saturation();
    rst = 1'b1; tick();
    rst = 1'b0; stall = 1'b1; flush = 1'b0;
    for (int k = 1; k <= 65540; k++) begin
      randomize_inputs();
      tick();
      n_checks++;
      if (scnt_w[0] !== exp_cnt(k) || bcnt_w[0] !== 16'h0000) begin
        n_errors++;
        $display("[TB] FAIL saturation cyc%0d: got sc=%h bc=%h, need sc=%h bc=0000", k, scnt_w[0], bcnt_w[0], exp_cnt(k));
      end
    end
    stall = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; stall = 1'b0; flush = 1'b0;
    ctrl_in = '0; data_in = '0; rd_in = '0;
    m_stall = 0; m_bubble = 0;
    for (int i = 0; i < 3; i++)
      for (int s = 0; s < 3; s++) mdl[i][s] = '0;
    test_reset();
    test_advance();
    test_stall_hold();
    test_flush_stall();
    test_invalid_ctrl();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage core, replacing the fixed-format stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one configurable block. It carries a valid bit, a control bundle, NDATA data channels and a destination-register address through DEPTH register stages. Every stage supports a global hold (memory stall) and bubble insertion (flush). It sits between any two pipeline stages and is instantiated once per stage boundary.

## Interface
- CTRL_W, 4: width of control bundle (RegWrite, MemtoReg, MemRead, MemWrite, ...); ≥1
- DATA_W, 32: width of each data channel
- NDATA, 2: number of data channels (e.g. ALU result, store data); ≥1
- ADDR_W, 5: destination register address width
- DEPTH, 1: number of register stages; ≥1, 0 is illegal
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous reset, active-high
- valid_i  in  1  incoming slot holds a real instruction
- stall_i  in  1  hold all stages (MemStall)
- flush_i  in  1  insert bubble into stage 0
- ctrl_i  in  CTRL_W  control bundle
- data_i  in  NDATA*DATA_W  data channels, channel k at bits [k*DATA_W +: DATA_W]
- rd_addr_i  in  ADDR_W  destination register
- valid_o  out  1  last-stage valid
- ctrl_o  out  CTRL_W  last-stage control
- data_o  out  NDATA*DATA_W  last-stage data
- rd_addr_o  out  ADDR_W  last-stage destination
- stall_cnt_o  out  16  stall-cycle counter (see Configuration)
- bubble_cnt_o  out  16  bubble counter (see Configuration)

## Operation
- Stage s (0..DEPTH-1) holds {valid, ctrl, data, rd_addr}. Stage 0 loads from inputs; stage s>0 loads from stage s-1. Outputs reflect stage DEPTH-1 directly (registered, no combinational path from inputs).
- Priority per edge: rst_i > flush_i > stall_i > normal advance.
- rst_i=1: every field of every stage ← 0; counters ← 0.
- flush_i=1, stall_i=0: stage 0 ← bubble; stages 1..DEPTH-1 advance normally.
- flush_i=1, stall_i=1: stage 0 ← bubble; stages 1..DEPTH-1 hold. The held instruction in stage 0 is killed.
- flush_i=0, stall_i=1: all stages hold all fields.
- flush_i=0, stall_i=0: all stages advance. Stage 0 loads the inputs if valid_i=1, otherwise a bubble.
- Bubble = valid 0, ctrl 0, data 0, rd_addr 0. No stage with valid=0 ever holds non-zero ctrl, so downstream never sees write-enables from a bubble.
- Data channels pass unaltered bit-for-bit. No sign handling is done in this block.

## Timing
- All outputs are 0 from the first edge with rst_i=1 until the first non-reset load reaches the last stage.
- Latency: an input accepted at edge N (stall_i=0) appears on the outputs after edge N+DEPTH-1, provided no stall occurs in between. Each stall cycle adds one cycle.
- A stall of any length preserves contents exactly. Inputs presented during a stall are dropped; upstream holds them.
- Reset asserted mid-stall or mid-flush clears everything on that edge. Releasing reset resumes normal operation on the next edge.
- DEPTH=1 behaves as a classic single pipeline latch with added flush and valid.

## Configuration
- PIPE_STAGE_PERF_EN defined: enables the two counters, both cleared by rst_i and saturating at 16'hFFFF.
  - stall_cnt_o increments on every edge with stall_i=1 and rst_i=0.
  - bubble_cnt_o increments on every edge where stage 0 loads a bubble with rst_i=0, whether caused by flush_i=1 or by valid_i=0 with stall_i=0.
- Not defined: no counter flops are built; stall_cnt_o and bubble_cnt_o are tied to 16'h0000. Datapath behaviour is identical in both builds.

## Test plan
- Reset: drive random inputs with rst_i=1 for 3 cycles -> valid_o=0, ctrl_o=0, data_o=0, rd_addr_o=0, counters 0.
- Advance, DEPTH=3: valid_i=1, ctrl_i=4'b1010, data_i={32'h1234_5678, 32'hDEAD_BEEF}, rd_addr_i=5'd7 at edge N, then bubbles -> these values appear on the outputs after edge N+2, and valid_o=0 the cycle after.
- Stall hold: DEPTH=1, with a valid entry (ctrl 4'b1111, rd 5'd3) in the stage, hold stall_i=1 for 4 cycles while the inputs change -> outputs unchanged throughout; with PIPE_STAGE_PERF_EN, stall_cnt_o=4.
- Flush during stall: DEPTH=2, stage 0 valid and stage 1 valid, assert flush_i=1 and stall_i=1 for one edge -> stage 0 becomes a bubble, stage 1 held. On the next non-stalled edge, valid_o=1 with the old stage-1 data, then valid_o=0 with ctrl_o=0.
- valid_i=0 with non-zero ctrl_i=4'b1111 and stall_i=0 -> after DEPTH edges, ctrl_o=0 and valid_o=0; bubble_cnt_o increments by 1.
- Counter saturation (macro defined): hold stall_i=1 for 65 540 cycles -> stall_cnt_o stays at 16'hFFFF. Without the macro, both counters read 0 in every cycle.
